reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 106 ++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a per-entry busy scoreboard; entry 0 is hard-wired zero.
// Optional write-to-read forwarding is enabled by defining REG_BYPASS_EN.
module reg_file_mp #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 3
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                RegW,
    input  logic [AW-1:0]       DR,
    input  logic [DW-1:0]       Reg_In,
    input  logic                Rsv,
    input  logic [AW-1:0]       RsvA,
    input  logic [NRD*AW-1:0]   SR,
    output logic [NRD*DW-1:0]   ReadReg,
    output logic [NRD-1:0]      ReadBusy
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem_r [DEPTH];
    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;
    logic             wr_en_s;
    logic             rsv_en_s;
    logic [AW-1:0]    rd_addr_s [NRD];
    logic [DW-1:0]    rd_data_s [NRD];
    logic [NRD-1:0]   rd_busy_s;

    // Qualify write and reserve so address 0 is never touched
    always_comb begin
        wr_en_s  = RegW && (DR != {AW{1'b0}});
        rsv_en_s = Rsv && (RsvA != {AW{1'b0}});
    end

    // Next busy vector: a reserve on the same entry overrides the write's clear
    always_comb begin
        busy_nxt_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (rsv_en_s && (RsvA == AW'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if (wr_en_s && (DR == AW'(i))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Data storage and busy bits
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            busy_r <= {DEPTH{1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[DR] <= Reg_In;
            end
            busy_r <= busy_nxt_s;
        end
    end

    // Unpack read addresses
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_addr_s[k] = SR[k*AW +: AW];
        end
    end

    // Read selection per port, with optional same-edge write forwarding
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_data_s[k] = {DW{1'b0}};
            rd_busy_s[k] = 1'b0;
            if (rd_addr_s[k] == {AW{1'b0}}) begin
                rd_data_s[k] = {DW{1'b0}};
                rd_busy_s[k] = 1'b0;
`ifdef REG_BYPASS_EN
            end else if (wr_en_s && (DR == rd_addr_s[k])) begin
                rd_data_s[k] = Reg_In;
                rd_busy_s[k] = busy_nxt_s[rd_addr_s[k]];
`endif
            end else begin
                rd_data_s[k] = mem_r[rd_addr_s[k]];
                rd_busy_s[k] = busy_r[rd_addr_s[k]];
            end
        end
    end

    // Registered read outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ReadReg  <= {(NRD*DW){1'b0}};
            ReadBusy <= {NRD{1'b0}};
        end else begin
            for (int k = 0; k < NRD; k++) begin
                ReadReg[k*DW +: DW] <= rd_data_s[k];
            end
            ReadBusy <= rd_busy_s;
        end
    end

endmodule
